fifo_uart_tx: RTL and testbench

// - Drain stage directly downstream of the 16x9 board FIFO.
// - When enabled and the FIFO is non-empty, pops one word via the FIFO's active-low Read strobe
//   and latches the word.
// - Serializes the word onto a UART TxD line: start bit, DATA_WIDTH data bits LSB-first,

---
 rtl/fifo_uart_tx.sv | 136 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Pops one word at a time from the board FIFO and sends each word as a UART frame:
// a start bit, the data bits LSB-first, an optional even-parity bit, then the stop bits.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 9,
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  FifoEmpty,
    input  logic [DATA_WIDTH-1:0] FifoDataOut,
    output logic                  ReadN,
    output logic                  TxD,
    output logic                  Busy,
    output logic                  Sent,
    output logic [7:0]            FrameCount
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift;
    logic                  parity;
    logic [CW-1:0]         baud;
    logic [IW-1:0]         bit_idx;
    logic                  bit_end;
    logic                  can_fetch;

    assign bit_end   = (baud == BAUD_LAST);
    assign can_fetch = Enable && !FifoEmpty;

    // Pop handshake: ReadN is low for exactly the FETCH cycle. The FIFO presents the
    // popped word on FifoDataOut during that cycle, and the word is captured at the end of LATCH.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            ReadN      <= 1'b1;
            TxD        <= 1'b1;
            Busy       <= 1'b0;
            Sent       <= 1'b0;
            FrameCount <= 8'd0;
            shift      <= '0;
            parity     <= 1'b0;
            baud       <= '0;
            bit_idx    <= '0;
        end else begin
            Sent  <= 1'b0;
            ReadN <= 1'b1;
            baud  <= '0;
            case (state)
                IDLE: begin
                    TxD <= 1'b1;
                    if (can_fetch) begin
                        state <= FETCH;
                        ReadN <= 1'b0;
                        Busy  <= 1'b1;
                    end
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    shift  <= FifoDataOut;
                    parity <= ^FifoDataOut;
                    TxD    <= 1'b0;
                    state  <= START;
                end
                START: begin
                    baud <= bit_end ? '0 : baud + 1'b1;
                    if (bit_end) begin
                        TxD     <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    baud <= bit_end ? '0 : baud + 1'b1;
                    if (bit_end) begin
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                TxD   <= parity;
                                state <= PARITY;
                            end else begin
                                TxD   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            TxD     <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                end
                PARITY: begin
                    baud <= bit_end ? '0 : baud + 1'b1;
                    if (bit_end) begin
                        TxD   <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    baud <= bit_end ? '0 : baud + 1'b1;
                    // Sent and FrameCount are raised one edge early so that both are visible
                    // during the final stop cycle itself.
                    if (bit_idx == STOP_LAST && baud == BAUD_PRE) begin
                        Sent       <= 1'b1;
                        FrameCount <= FrameCount + 8'd1;
                    end
                    if (bit_end) begin
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (can_fetch) begin
                                state <= FETCH;
                                ReadN <= 1'b0;
                            end else begin
                                state <= IDLE;
                                Busy  <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a behavioural FIFO plus a bit-level model of the frame waveform.
// Instance dut0 has no parity bit; instance dut1 appends an even-parity bit.
module tb_fifo_uart_tx;
    localparam int DW  = 9;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          sel = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] data_out = '0;

    logic       empty0, empty1;
    logic       read_n0, tx0, busy0, sent0;
    logic       read_n1, tx1, busy1, sent1;
    logic [7:0] fc0, fc1;
    logic       read_n, tx, busy, sent;
    logic [7:0] frame_count;

    assign empty0      = sel ? 1'b1 : fifo_empty;
    assign empty1      = sel ? fifo_empty : 1'b1;
    assign read_n      = sel ? read_n1 : read_n0;
    assign tx          = sel ? tx1 : tx0;
    assign busy        = sel ? busy1 : busy0;
    assign sent        = sel ? sent1 : sent0;
    assign frame_count = sel ? fc1 : fc0;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .Clock(clk), .Reset(rst_n), .Enable(enable), .FifoEmpty(empty0), .FifoDataOut(data_out),
        .ReadN(read_n0), .TxD(tx0), .Busy(busy0), .Sent(sent0), .FrameCount(fc0));

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
        .Clock(clk), .Reset(rst_n), .Enable(enable), .FifoEmpty(empty1), .FifoDataOut(data_out),
        .ReadN(read_n1), .TxD(tx1), .Busy(busy1), .Sent(sent1), .FrameCount(fc1));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int tick_no = 0;
    int n_fetch = 0;
    int n_sent = 0;
    int model_cnt[2];
    logic [DW-1:0] fifo_q[$];
    logic [1:0]    exp_q[$];     // {last stop cycle, expected TxD} per clock cycle
    logic          tx_log[$];
    int            fetch_ticks[$];
    int            sent_ticks[$];

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Expected line activity after a pop: one LATCH cycle, then the frame bit by bit.
    task automatic push_frame(input logic [DW-1:0] w, input logic par);
        int ones = 0;
        exp_q.push_back(2'b01);
        repeat (CPB) exp_q.push_back(2'b00);
        for (int b = 0; b < DW; b++) begin
            if (w[b]) ones++;
            repeat (CPB) exp_q.push_back({1'b0, w[b]});
        end
        if (par) repeat (CPB) exp_q.push_back({1'b0, ones[0]});
        repeat (CPB - 1) exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
    endtask

    task automatic tick();
        logic          pred_fetch, exp_busy;
        logic [1:0]    e;
        logic [DW-1:0] w_pred;
        pred_fetch = (exp_q.size() == 0) && enable && (fifo_q.size() != 0);
        w_pred = '0;
        if (pred_fetch) w_pred = fifo_q[0];
        exp_busy = pred_fetch || (exp_q.size() != 0);
        e = 2'b01;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        @(negedge clk);
        tick_no++;
        if (e[1]) model_cnt[sel] = (model_cnt[sel] + 1) % 256;
        checks += 5;
        if (read_n !== ~pred_fetch) begin
            failures++; $display("FAIL read_n t=%0d: got %b expected %b", tick_no, read_n, ~pred_fetch);
        end
        if (tx !== e[0]) begin
            failures++; $display("FAIL txd t=%0d: got %b expected %b", tick_no, tx, e[0]);
        end
        if (sent !== e[1]) begin
            failures++; $display("FAIL sent t=%0d: got %b expected %b", tick_no, sent, e[1]);
        end
        if (busy !== exp_busy) begin
            failures++; $display("FAIL busy t=%0d: got %b expected %b", tick_no, busy, exp_busy);
        end
        if (frame_count !== 8'(model_cnt[sel])) begin
            failures++; $display("FAIL frame_count t=%0d: got %0d expected %0d", tick_no, frame_count, model_cnt[sel]);
        end
        if (read_n === 1'b0) begin
            checks++;
            if (fifo_q.size() == 0) begin
                failures++; $display("FAIL pop_when_empty t=%0d: got read_n=0 expected 1", tick_no);
            end else begin
                data_out = fifo_q.pop_front();
                n_fetch++;
                fetch_ticks.push_back(tick_no);
            end
        end
        if (pred_fetch) push_frame(w_pred, sel);
        if (sent === 1'b1) begin
            n_sent++;
            sent_ticks.push_back(tick_no);
        end
        tx_log.push_back(tx);
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || (enable && fifo_q.size() != 0)) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++; $display("FAIL idle_timeout: got %0d cycles expected < %0d", n, budget);
        end
        repeat (3) tick();
    endtask

    task automatic clear_logs();
        n_fetch = 0;
        n_sent = 0;
        tx_log.delete();
        fetch_ticks.delete();
        sent_ticks.delete();
    endtask

    // Asynchronous reset asserted between clock edges; outputs must react before the next edge.
    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (read_n !== 1'b1) begin failures++; $display("FAIL rst_read_n: got %b expected 1", read_n); end
        if (tx !== 1'b1) begin failures++; $display("FAIL rst_txd: got %b expected 1", tx); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (sent !== 1'b0) begin failures++; $display("FAIL rst_sent: got %b expected 0", sent); end
        if (frame_count !== 8'd0) begin failures++; $display("FAIL rst_frame_count: got %0d expected 0", frame_count); end
        exp_q.delete();
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_pulse();
        repeat (5) tick();
    endtask

    task automatic test_single_word();
        logic [10:0] pat;
        int first_zero;
        pat = 11'b11101001010;
        sel = 1'b0;
        clear_logs();
        push_word(9'h1A5);
        enable = 1'b1;
        run_until_idle(200);
        first_zero = -1;
        for (int i = tx_log.size() - 1; i >= 0; i--) if (tx_log[i] == 1'b0) first_zero = i;
        checks += 4;
        if (n_fetch != 1) begin failures++; $display("FAIL single_pops: got %0d expected 1", n_fetch); end
        if (n_sent != 1) begin failures++; $display("FAIL single_sent: got %0d expected 1", n_sent); end
        if (frame_count !== 8'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", frame_count); end
        if (first_zero != 2) begin failures++; $display("FAIL single_latency: got %0d expected 2", first_zero); end
        if (first_zero == 2) begin
            for (int k = 0; k < 11; k++) begin
                checks++;
                if (tx_log[4 + k * CPB] !== pat[k]) begin
                    failures++; $display("FAIL single_bit%0d: got %b expected %b", k, tx_log[4 + k * CPB], pat[k]);
                end
            end
        end
    endtask

    task automatic test_parity();
        sel = 1'b1;
        clear_logs();
        push_word(9'h1A5);
        enable = 1'b1;
        run_until_idle(200);
        checks += 3;
        if (n_sent != 1 || n_fetch != 1) begin
            failures++; $display("FAIL parity_frames: got %0d/%0d expected 1/1", n_fetch, n_sent);
        end else if (sent_ticks[0] - fetch_ticks[0] + 1 != 50) begin
            failures++; $display("FAIL parity_length: got %0d expected 50", sent_ticks[0] - fetch_ticks[0] + 1);
        end
        if (tx_log[44] !== 1'b1) begin failures++; $display("FAIL parity_bit: got %b expected 1", tx_log[44]); end
        if (frame_count !== 8'd1) begin failures++; $display("FAIL parity_count: got %0d expected 1", frame_count); end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        reset_pulse();
        clear_logs();
        push_word(9'h000);
        push_word(9'h1FF);
        push_word(9'h055);
        enable = 1'b1;
        run_until_idle(500);
        checks += 3;
        if (n_fetch != 3) begin failures++; $display("FAIL b2b_pops: got %0d expected 3", n_fetch); end
        if (n_sent != 3) begin failures++; $display("FAIL b2b_sent: got %0d expected 3", n_sent); end
        if (frame_count !== 8'd3) begin failures++; $display("FAIL b2b_count: got %0d expected 3", frame_count); end
        if (n_fetch == 3 && n_sent == 3) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (fetch_ticks[k + 1] != sent_ticks[k] + 1) begin
                    failures++; $display("FAIL b2b_gap%0d: got fetch at %0d expected %0d", k, fetch_ticks[k + 1], sent_ticks[k] + 1);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        sel = 1'b0;
        clear_logs();
        push_word(9'($urandom_range(0, 511)));
        push_word(9'($urandom_range(0, 511)));
        enable = 1'b1;
        for (int c = 0; c < 20 && n_fetch == 0; c++) tick();
        repeat (15) tick();
        enable = 1'b0;
        run_until_idle(200);
        repeat (20) tick();
        checks += 2;
        if (fifo_q.size() != 1) begin failures++; $display("FAIL drop_fifo_left: got %0d expected 1", fifo_q.size()); end
        if (n_sent != 1) begin failures++; $display("FAIL drop_sent: got %0d expected 1", n_sent); end
        enable = 1'b1;
        run_until_idle(200);
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        clear_logs();
        push_word(9'h13C);
        enable = 1'b1;
        for (int c = 0; c < 20 && n_fetch == 0; c++) tick();
        repeat (15) tick();
        reset_pulse();
        clear_logs();
        push_word(9'h0F3);
        run_until_idle(200);
        checks += 2;
        if (n_sent != 1) begin failures++; $display("FAIL resume_sent: got %0d expected 1", n_sent); end
        if (frame_count !== 8'd1) begin failures++; $display("FAIL resume_count: got %0d expected 1", frame_count); end
    endtask

    task automatic test_random();
        for (int burst = 0; burst < 6; burst++) begin
            sel = 1'($urandom_range(0, 1));
            enable = 1'b1;
            repeat ($urandom_range(1, 4)) push_word(9'($urandom_range(0, 511)));
            for (int c = 0; c < 300; c++) begin
                tick();
                if ($urandom_range(0, 19) == 0) enable = ~enable;
                if ($urandom_range(0, 39) == 0 && fifo_q.size() < 16) push_word(9'($urandom_range(0, 511)));
            end
            enable = 1'b1;
            run_until_idle(2000);
        end
    endtask

    task automatic test_wrap();
        int pushed = 0;
        sel = 1'b0;
        reset_pulse();
        clear_logs();
        enable = 1'b1;
        for (int c = 0; c < 14000 && n_sent < 256; c++) begin
            if (fifo_q.size() < 4 && pushed < 256) begin
                push_word(9'($urandom_range(0, 511)));
                pushed++;
            end
            tick();
        end
        run_until_idle(200);
        checks += 2;
        if (n_sent != 256) begin failures++; $display("FAIL wrap_sent: got %0d expected 256", n_sent); end
        if (frame_count !== 8'd0) begin failures++; $display("FAIL wrap_count: got %0d expected 0", frame_count); end
    endtask

    initial begin
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        test_reset();
        test_single_word();
        test_parity();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion expected finish before 800000");
        $fatal(1);
    end
endmodule
